// File: rtl/pattern_checker_pkg.sv
// Shared types and constants for the pattern_checker memory game.
package pattern_checker_pkg;

  localparam int CODE_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    APPEND,
    SHOW_ON,
    SHOW_OFF,
    INPUT,
    WIN,
    LOSE
  } state_t;

endpackage

// File: rtl/pattern_checker_step.sv
// step_timer: loadable down-counter; done pulses in the last cycle of a loaded phase.
// A load of N-1 therefore spans exactly N cycles, with done high in the final one.
module step_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;
  logic             active;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count  <= '0;
      active <= 1'b0;
    end else if (load) begin
      count  <= load_value;
      active <= 1'b1;
    end else if (active) begin
      if (count == '0) active <= 1'b0;
      else             count  <= count - WIDTH'(1);
    end
  end

  assign done = active && (count == '0);

endmodule

// File: rtl/pattern_checker.sv
// pattern_checker: Simon-style sequence game (append, display, collect presses).
// Optional INPUT_TIMEOUT_EN: a press-idle limit of TIMEOUT_CYCLES in INPUT loses the game.
module pattern_checker
  import pattern_checker_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int SHOW_CYCLES    = 25000000,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            randnum,
  input  logic                  btn_valid,
  input  logic [CODE_W-1:0]     btn_code,
  output logic                  show_valid,
  output logic [CODE_W-1:0]     show_code,
  output logic [$clog2(DEPTH):0] level,
  output logic                  awaiting_input,
  output logic                  game_won,
  output logic                  game_lost
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;
  localparam int SW = $clog2(SHOW_CYCLES + 1);

  if (DEPTH < 2 || DEPTH > 32) begin : g_bad_depth
    $error("pattern_checker: DEPTH out of range");
  end
  if (SHOW_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
    $error("pattern_checker: cycle counts must be >= 1");
  end

  state_t            state, state_next;
  logic [LW-1:0]     level_next;
  logic [IW-1:0]     idx, idx_next;
  logic [CODE_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic              show_load, show_done;
  logic              idx_last, level_full, btn_match;
  logic              unused_randnum;

  assign unused_randnum = randnum[2];

  step_timer #(.WIDTH(SW)) u_show_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (show_load),
    .load_value (SW'(SHOW_CYCLES - 1)),
    .done       (show_done)
  );

`ifdef INPUT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic idle_load, idle_done;

  step_timer #(.WIDTH(TW)) u_idle_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (idle_load),
    .load_value (TW'(TIMEOUT_CYCLES - 1)),
    .done       (idle_done)
  );
`endif

  assign idx_last   = ({1'b0, idx} == level - LW'(1));
  assign level_full = (level == LW'(DEPTH));
  assign btn_match  = (btn_code == mem[idx]);

  always_comb begin
    state_next = state;
    level_next = level;
    idx_next   = idx;
    mem_we     = 1'b0;
    show_load  = 1'b0;
`ifdef INPUT_TIMEOUT_EN
    idle_load  = 1'b0;
`endif
    if (start) begin
      state_next = APPEND;
      level_next = '0;
      idx_next   = '0;
    end else begin
      case (state)
        IDLE: ;
        APPEND: begin
          mem_we     = 1'b1;
          level_next = level + LW'(1);
          idx_next   = '0;
          show_load  = 1'b1;
          state_next = SHOW_ON;
        end
        SHOW_ON: if (show_done) begin
          show_load  = 1'b1;
          state_next = SHOW_OFF;
        end
        SHOW_OFF: if (show_done) begin
          if (idx_last) begin
            idx_next   = '0;
            state_next = INPUT;
`ifdef INPUT_TIMEOUT_EN
            idle_load  = 1'b1;
`endif
          end else begin
            idx_next   = idx + IW'(1);
            show_load  = 1'b1;
            state_next = SHOW_ON;
          end
        end
        INPUT: begin
          if (btn_valid) begin
            if (!btn_match)      state_next = LOSE;
            else if (!idx_last) begin
              idx_next = idx + IW'(1);
`ifdef INPUT_TIMEOUT_EN
              idle_load = 1'b1;
`endif
            end
            else if (level_full) state_next = WIN;
            else                 state_next = APPEND;
          end
`ifdef INPUT_TIMEOUT_EN
          else if (idle_done) state_next = LOSE;
`endif
        end
        WIN, LOSE: ;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      level <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      level <= level_next;
      idx   <= idx_next;
    end
  end

  // Memory is left unreset: every slot is written in APPEND before it can be read.
  always_ff @(posedge clock) begin
    if (mem_we) mem[level[IW-1:0]] <= randnum[CODE_W-1:0];
  end

  always_comb begin
    show_valid     = (state == SHOW_ON);
    show_code      = (state == SHOW_ON) ? mem[idx] : '0;
    awaiting_input = (state == INPUT);
    game_won       = (state == WIN);
    game_lost      = (state == LOSE);
  end

endmodule

// File: tb/tb_pattern_checker.sv
// Directed, table-driven bench for pattern_checker (DEPTH=4, SHOW_CYCLES=2, TIMEOUT_CYCLES=10).
module tb_pattern_checker;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] randnum;
  logic       btn_valid;
  logic [1:0] btn_code;
  logic       show_valid;
  logic [1:0] show_code;
  logic [2:0] level;
  logic       awaiting_input;
  logic       game_won;
  logic       game_lost;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       st;
    logic [2:0] rn;
    logic       bv;
    logic [1:0] bc;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  pattern_checker #(.DEPTH(4), .SHOW_CYCLES(2), .TIMEOUT_CYCLES(10)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .randnum        (randnum),
    .btn_valid      (btn_valid),
    .btn_code       (btn_code),
    .show_valid     (show_valid),
    .show_code      (show_code),
    .level          (level),
    .awaiting_input (awaiting_input),
    .game_won       (game_won),
    .game_lost      (game_lost)
  );

  always #5 clock = ~clock;

  // Expected-output packing: {show_valid, show_code, level, awaiting, won, lost}
  function automatic logic [8:0] pack(input logic sv, input logic [1:0] sc, input logic [2:0] lv,
                                      input logic aw, input logic won, input logic lost);
    return {sv, sc, lv, aw, won, lost};
  endfunction

  task automatic add(input logic st, input logic [2:0] rn, input logic bv, input logic [1:0] bc,
                     input logic sv, input logic [1:0] sc, input logic [2:0] lv,
                     input logic aw, input logic won, input logic lost);
    vec_t v;
    v.st = st; v.rn = rn; v.bv = bv; v.bc = bc;
    v.exp = pack(sv, sc, lv, aw, won, lost);
    vecs.push_back(v);
  endtask

  // One displayed step: two ON cycles then two OFF cycles. rn only matters when the
  // first row's edge is the APPEND cycle.
  task automatic add_show(input logic [2:0] rn, input logic [1:0] code, input logic [2:0] lv);
    add(0, rn, 0, 0, 1, code, lv, 0, 0, 0);
    add(0, 0,  0, 0, 1, code, lv, 0, 0, 0);
    add(0, 0,  0, 0, 0, 0,    lv, 0, 0, 0);
    add(0, 0,  0, 0, 0, 0,    lv, 0, 0, 0);
  endtask

  task automatic add_input(input logic [2:0] lv);
    add(0, 0, 0, 0, 0, 0, lv, 1, 0, 0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] act;
    act = {show_valid, show_code, level, awaiting_input, game_won, game_lost};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (sv,code[2],level[3],await,won,lost)", name, act, exp);
    end
  endtask

  initial begin
    bit found;

    // Full 4-round win, then a loss, then btn presses during display.
    add(1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    add_show(6, 2, 1); add_input(1);
    add(0, 1, 1, 2, 0, 0, 1, 0, 0, 0);
    add_show(1, 2, 2); add_show(0, 1, 2); add_input(2);
    add(0, 0, 1, 2, 0, 0, 2, 1, 0, 0);
    add(0, 3, 1, 1, 0, 0, 2, 0, 0, 0);
    add_show(3, 2, 3); add_show(0, 1, 3); add_show(0, 3, 3); add_input(3);
    add(0, 0, 1, 2, 0, 0, 3, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0, 3, 1, 0, 0);
    add(0, 0, 1, 3, 0, 0, 3, 0, 0, 0);
    add_show(0, 2, 4); add_show(0, 1, 4); add_show(0, 3, 4); add_show(0, 0, 4); add_input(4);
    add(0, 0, 1, 2, 0, 0, 4, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0, 4, 1, 0, 0);
    add(0, 0, 1, 3, 0, 0, 4, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 4, 0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 4, 0, 1, 0);
    add(0, 0, 1, 2, 0, 0, 4, 0, 1, 0);
    add(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    add_show(5, 1, 1); add_input(1);
    add(0, 0, 1, 3, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    add(1, 6, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 6, 1, 0, 1, 2, 1, 0, 0, 0);
    add(0, 0, 1, 1, 1, 2, 1, 0, 0, 0);
    add(0, 0, 1, 2, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 3, 0, 0, 1, 0, 0, 0);
    add_input(1);
    add(0, 1, 1, 2, 0, 0, 1, 0, 0, 0);
    add_show(1, 2, 2); add_show(0, 1, 2); add_input(2);

    reset = 1'b0; start = 1'b0; randnum = '0; btn_valid = 1'b0; btn_code = '0;
    repeat (3) step();
    check("reset_state", '0);
    reset = 1'b1;
    step();
    check("idle_after_release", '0);

    foreach (vecs[i]) begin
      start = vecs[i].st; randnum = vecs[i].rn;
      btn_valid = vecs[i].bv; btn_code = vecs[i].bc;
      step();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end
    start = 1'b0; btn_valid = 1'b0; btn_code = '0; randnum = '0;

    // Reset in the middle of SHOW_ON.
    start = 1'b1; randnum = 3'd6;
    step();
    start = 1'b0;
    step();
    check("show_before_reset", pack(1, 2, 1, 0, 0, 0));
    reset = 1'b0;
    step();
    check("reset_mid_show", '0);
    reset = 1'b1;
    step();
    check("idle_after_mid_reset", '0);

    // Idle in INPUT: timeout build loses after 10 cycles, default build waits.
    start = 1'b1; randnum = 3'd7;
    step();
    start = 1'b0;
    step();
    randnum = '0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (awaiting_input) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL reach_input: awaiting_input never rose within 20 cycles, expected it to");
    end
`ifdef INPUT_TIMEOUT_EN
    repeat (9) step();
    check("timeout_not_yet", pack(0, 0, 1, 1, 0, 0));
    step();
    check("timeout_lose", pack(0, 0, 1, 0, 0, 1));
`else
    repeat (100) step();
    check("no_timeout", pack(0, 0, 1, 1, 0, 0));
    btn_valid = 1'b1; btn_code = 2'd3;
    step();
    btn_valid = 1'b0;
    check("press_after_wait", pack(0, 0, 1, 0, 0, 0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_checker.md
PATTERN_CHECKER -- requirements
Module: pattern_checker

Interface
REQ-001 SHALL have parameter DEPTH, default 16, maximum sequence length in steps (2..32).
REQ-002 SHALL have parameter SHOW_CYCLES, default 25000000, clock cycles per display ON phase and per OFF phase (>=1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 250000000, input idle limit, used only under INPUT_TIMEOUT_EN.
REQ-004 clock  in  1  rising-edge system clock.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse; begins a new game.
REQ-007 randnum  in  3  random value from the LFSR generator; only bits [1:0] are consumed.
REQ-008 btn_valid  in  1  one-cycle pulse; player pressed a button.
REQ-009 btn_code  in  2  button identity, sampled only when btn_valid=1.
REQ-010 show_valid  out  1  high while a stored step is being displayed.
REQ-011 show_code  out  2  code of the step being displayed; 0 when show_valid=0.
REQ-012 level  out  clog2(DEPTH)+1  current stored sequence length.
REQ-013 awaiting_input  out  1  high while in INPUT.
REQ-014 game_won / game_lost  out  1 each  held high in WIN / LOSE respectively.

Function
REQ-015 SHALL implement states IDLE, APPEND, SHOW_ON, SHOW_OFF, INPUT, WIN, LOSE.
REQ-016 start=1 in any state SHALL set level=0 and go to APPEND next cycle; start SHALL take priority over btn_valid and any other transition in the same cycle.
REQ-017 APPEND (one cycle): mem[level] <= randnum[1:0], level <= level+1, step index idx <= 0, -> SHOW_ON.
REQ-018 SHOW_ON: show_valid=1, show_code=mem[idx] for exactly SHOW_CYCLES cycles, -> SHOW_OFF.
REQ-019 SHOW_OFF: show_valid=0 for exactly SHOW_CYCLES cycles; then if idx==level-1 -> INPUT with idx<=0, else idx<=idx+1 and -> SHOW_ON.
REQ-020 INPUT, btn_valid=1 and btn_code==mem[idx]: if idx<level-1 then idx<=idx+1 and stay; if idx==level-1 and level==DEPTH -> WIN; if idx==level-1 and level<DEPTH -> APPEND.
REQ-021 INPUT, btn_valid=1 and btn_code!=mem[idx]: -> LOSE.
REQ-022 btn_valid outside INPUT SHALL be ignored, with no effect on state, idx, or memory.
REQ-023 WIN and LOSE SHALL hold until start; level SHALL retain its final value there.
REQ-024 level SHALL never exceed DEPTH; idx SHALL never exceed level-1.
REQ-025 All outputs SHALL be registered or decoded from the state register only, with no combinational path from inputs.

Reset
REQ-026 reset=0 at a clock edge SHALL force IDLE, level=0, idx=0, timers=0, and all outputs 0 on the next cycle, including mid-display or mid-input.
REQ-027 Sequence memory contents SHALL NOT be reset; they are always rewritten before being read.

Configuration
REQ-028 With INPUT_TIMEOUT_EN defined, an idle counter SHALL clear on INPUT entry and on each accepted btn_valid; reaching TIMEOUT_CYCLES in INPUT SHALL -> LOSE.
REQ-029 Without INPUT_TIMEOUT_EN, INPUT SHALL wait indefinitely, and neither the idle counter nor the TIMEOUT_CYCLES logic SHALL be present.

Structure
REQ-030 Package pattern_checker_pkg SHALL hold the state enum and the CODE_W=2 constant.
REQ-031 Phase timing SHALL use one sub-module, step_timer: loadable down-counter with a done pulse, instantiated once for SHOW phases and, under INPUT_TIMEOUT_EN, once for timeout.

Verification (DEPTH=4, SHOW_CYCLES=2, TIMEOUT_CYCLES=10)
REQ-032 Reset, then start with randnum=3'b110 -> level=1; show_valid high 2 cycles with show_code=2; low 2 cycles; then awaiting_input=1.
REQ-033 Round 1 expects code 2, btn_code=2 pressed, next randnum=3'b001 -> level=2; display sequence 2,1; awaiting_input.
REQ-034 Presses matching all 4 rounds correctly -> game_won=1 with level=4; further btn_valid has no effect.
REQ-035 Expected code 1, btn_code=3 pressed -> game_lost=1; start then -> level=1, game_lost=0.
REQ-036 btn_valid during SHOW_ON -> ignored, and the display sequence is unchanged; reset=0 asserted mid-SHOW_ON -> all outputs 0 next cycle, state IDLE.
REQ-037 With INPUT_TIMEOUT_EN, no press for 10 cycles in INPUT -> game_lost=1; without it, awaiting_input is still 1 after 100 cycles.
